// File: rtl/contour_pkg.sv
// contour_pkg
// Purpose: frame geometry, bus widths and FSM state encodings shared by the
//          contour seed finder and the contour tracer.
// Ports:   none (package).
package contour_pkg;

  localparam int H_PIXELS     = 640;
  localparam int V_PIXELS     = 480;
  localparam int FRAME_PIXELS = H_PIXELS * V_PIXELS;
  localparam int ADDR_W       = 19;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seed_state_e;

  // Interior means the tracer's +/-1 and +/-row neighbours never leave the frame.
  function automatic logic is_interior(input logic [X_W-1:0] x,
                                       input logic [Y_W-1:0] y,
                                       input logic [X_W-1:0] x_max,
                                       input logic [Y_W-1:0] y_max);
    return (x != '0) && (x <= x_max) && (y != '0) && (y <= y_max);
  endfunction

endpackage

// File: rtl/scan_delay_line.sv
// scan_delay_line
// Purpose: fixed-depth shift register that carries the scan context
//          {valid, x, y, addr} alongside the BRAM read so it lines up with
//          the returned data.
// Ports:   clk, reset (async, active-high), data_i (context in),
//          data_o (context delayed by DEPTH cycles).
module scan_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/contour_seed_finder.sv
// contour_seed_finder
// Purpose: raster-scans the edge-map BRAM once per scan_go, latches the first
//          interior edge pixel as the tracer seed, counts interior edge pixels
//          (saturating) and holds contour_start high once the scan is done.
// Ports:   clk, reset (async, active-high), scan_go (start pulse),
//          addr/edge_out (BRAM read port), busy, done, seed_found,
//          x_start/y_start/addr_start (seed), num_pixels (count),
//          contour_start (level, done & seed_found).
//
// state | meaning
// IDLE  | waiting for the first scan_go after reset
// SCAN  | issuing one read address per cycle, 0..frame-1
// DRAIN | waiting READ_LATENCY cycles for the last reads to return
// DONE  | results valid and held; scan_go restarts the scan
module contour_seed_finder #(
  parameter int H_PIXELS     = contour_pkg::H_PIXELS,
  parameter int V_PIXELS     = contour_pkg::V_PIXELS,
  parameter int READ_LATENCY = 2,
  parameter int COUNT_W      = 12
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           scan_go,
  output logic [contour_pkg::ADDR_W-1:0] addr,
  input  logic [2:0]                     edge_out,
  output logic                           busy,
  output logic                           done,
  output logic                           seed_found,
  output logic [contour_pkg::X_W-1:0]    x_start,
  output logic [contour_pkg::Y_W-1:0]    y_start,
  output logic [contour_pkg::ADDR_W-1:0] addr_start,
  output logic [COUNT_W-1:0]             num_pixels,
  output logic                           contour_start
);

  import contour_pkg::*;

  localparam int FRAME   = H_PIXELS * V_PIXELS;
  localparam int DL_W    = 1 + X_W + Y_W + ADDR_W;
  localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(FRAME - 1);
  localparam logic [X_W-1:0]     X_LAST    = X_W'(H_PIXELS - 1);
  localparam logic [X_W-1:0]     X_IN_MAX  = X_W'(H_PIXELS - 2);
  localparam logic [Y_W-1:0]     Y_IN_MAX  = Y_W'(V_PIXELS - 2);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  seed_state_e        state_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [X_W-1:0]     seed_x_q;
  logic [Y_W-1:0]     seed_y_q;
  logic [ADDR_W-1:0]  seed_addr_q;
  logic               seed_found_q;
  logic [COUNT_W-1:0] count_q;
  logic               done_q;
  logic               cs_q;

  logic [DL_W-1:0]    dl_in;
  logic [DL_W-1:0]    dl_out;
  logic               dl_valid;
  logic [X_W-1:0]     dl_x;
  logic [Y_W-1:0]     dl_y;
  logic [ADDR_W-1:0]  dl_addr;
  logic               hit;

  assign dl_in = {(state_q == ST_SCAN), x_q, y_q, addr_q};

  scan_delay_line #(
    .DEPTH (READ_LATENCY),
    .W     (DL_W)
  ) u_delay (
    .clk    (clk),
    .reset  (reset),
    .data_i (dl_in),
    .data_o (dl_out)
  );

  assign {dl_valid, dl_x, dl_y, dl_addr} = dl_out;
  assign hit = dl_valid && (edge_out != 3'd0) && is_interior(dl_x, dl_y, X_IN_MAX, Y_IN_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      drain_q      <= '0;
      seed_x_q     <= '0;
      seed_y_q     <= '0;
      seed_addr_q  <= '0;
      seed_found_q <= 1'b0;
      count_q      <= '0;
      done_q       <= 1'b0;
      cs_q         <= 1'b0;
    end else begin
      if (hit) begin
        if (!seed_found_q) begin
          seed_x_q     <= dl_x;
          seed_y_q     <= dl_y;
          seed_addr_q  <= dl_addr;
          seed_found_q <= 1'b1;
        end
        if (count_q != COUNT_MAX) count_q <= count_q + COUNT_W'(1);
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (scan_go) begin
            state_q      <= ST_SCAN;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            seed_x_q     <= '0;
            seed_y_q     <= '0;
            seed_addr_q  <= '0;
            seed_found_q <= 1'b0;
            count_q      <= '0;
            done_q       <= 1'b0;
            cs_q         <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (addr_q == ADDR_LAST) begin
            state_q <= ST_DRAIN;
            drain_q <= DRAIN_W'(READ_LATENCY - 1);
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + Y_W'(1);
            end else begin
              x_q <= x_q + X_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            // The final read is sampled on this same edge, so include it.
            cs_q    <= seed_found_q | hit;
          end else begin
            drain_q <= drain_q - DRAIN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign addr          = addr_q;
  assign busy          = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done          = done_q;
  assign seed_found    = seed_found_q;
  assign x_start       = seed_x_q;
  assign y_start       = seed_y_q;
  assign addr_start    = seed_addr_q;
  assign num_pixels    = count_q;
  assign contour_start = cs_q;

endmodule
